// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and a variable-latency instruction memory (slave).
interface fetch_stage_if #(
    parameter int WORD_LEN = 32
);
    logic                req;
    logic [WORD_LEN-1:0] addr;
    logic                ready;
    logic [WORD_LEN-1:0] data;

    modport master (output req, addr, input ready, data);
    modport slave  (input req, addr, output ready, data);
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, variable-latency instruction fetch, IF/ID register,
// and branch redirect with squash of any wrong-path fetch (no delay slot).
module fetch_stage #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                brTaken,
    input  logic [WORD_LEN-1:0] brTarget,
    fetch_stage_if.master       imem,
    output logic [WORD_LEN-1:0] pc,
    output logic [WORD_LEN-1:0] ifIdPC,
    output logic [WORD_LEN-1:0] ifIdInstr,
    output logic                ifIdValid
);
    localparam logic [WORD_LEN-1:0] STEP = WORD_LEN'(PC_STEP);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t              state_reg;
    logic [WORD_LEN-1:0] pc_reg;
    logic [WORD_LEN-1:0] if_id_pc_reg;
    logic [WORD_LEN-1:0] if_id_instr_reg;
    logic                if_id_valid_reg;
    logic [WORD_LEN-1:0] buf_pc_reg;
    logic [WORD_LEN-1:0] buf_instr_reg;
    logic [WORD_LEN-1:0] saved_target_reg;

    logic                take;
    logic [WORD_LEN-1:0] pc_next;

    // A branch only counts when it belongs to a real instruction that ID is consuming.
    always_comb begin
        take    = brTaken & if_id_valid_reg & ~freeze;
        pc_next = pc_reg + STEP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= FETCH;
            pc_reg           <= RESET_PC;
            if_id_pc_reg     <= '0;
            if_id_instr_reg  <= '0;
            if_id_valid_reg  <= 1'b0;
            buf_pc_reg       <= '0;
            buf_instr_reg    <= '0;
            saved_target_reg <= '0;
        end else begin
            unique case (state_reg)
                FETCH: begin
                    if (take && imem.ready) begin
                        pc_reg          <= brTarget;
                        if_id_valid_reg <= 1'b0;
                    end else if (take) begin
                        // Request address must stay put, so park the target until it completes.
                        saved_target_reg <= brTarget;
                        if_id_valid_reg  <= 1'b0;
                        state_reg        <= DISCARD;
                    end else if (imem.ready && !freeze) begin
                        if_id_pc_reg    <= pc_next;
                        if_id_instr_reg <= imem.data;
                        if_id_valid_reg <= 1'b1;
                        pc_reg          <= pc_next;
                    end else if (imem.ready) begin
                        buf_pc_reg    <= pc_next;
                        buf_instr_reg <= imem.data;
                        pc_reg        <= pc_next;
                        state_reg     <= HOLD;
                    end else if (!freeze) begin
                        if_id_valid_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        if (take) begin
                            pc_reg          <= brTarget;
                            if_id_valid_reg <= 1'b0;
                        end else begin
                            if_id_pc_reg    <= buf_pc_reg;
                            if_id_instr_reg <= buf_instr_reg;
                            if_id_valid_reg <= 1'b1;
                        end
                        state_reg <= FETCH;
                    end
                end
                DISCARD: begin
                    if (imem.ready) begin
                        pc_reg    <= saved_target_reg;
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign imem.req  = (state_reg != HOLD);
    assign imem.addr = pc_reg;
    assign pc        = pc_reg;
    assign ifIdPC    = if_id_pc_reg;
    assign ifIdInstr = if_id_instr_reg;
    assign ifIdValid = if_id_valid_reg;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then randomized traffic scored against
// a program-order model (sequential PCs, redirected by accepted branches).
module tb_fetch_stage;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        brTaken = 1'b0;
    logic [31:0] brTarget = '0;
    logic [31:0] pc, ifIdPC, ifIdInstr;
    logic        ifIdValid;
    logic [31:0] pc2, ifIdPC2, ifIdInstr2;
    logic        ifIdValid2;

    int tests = 0;
    int fails = 0;

    fetch_stage_if #(.WORD_LEN(32)) bus ();
    fetch_stage_if #(.WORD_LEN(32)) bus2 ();

    assign bus.data  = bus.ready ? (bus.addr ^ K) : 32'hDEAD_BEEF;
    assign bus2.ready = 1'b1;
    assign bus2.data  = bus2.addr ^ K;

    fetch_stage #(.WORD_LEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .brTaken(brTaken), .brTarget(brTarget),
        .imem(bus), .pc(pc), .ifIdPC(ifIdPC), .ifIdInstr(ifIdInstr), .ifIdValid(ifIdValid)
    );

    fetch_stage #(.WORD_LEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clk(clk), .rst(rst), .freeze(1'b0), .brTaken(1'b0), .brTarget(32'h0),
        .imem(bus2), .pc(pc2), .ifIdPC(ifIdPC2), .ifIdInstr(ifIdInstr2), .ifIdValid(ifIdValid2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard state
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    int          consumed = 0;
    bit          sb_en = 1'b0;
    bit          have_prev = 1'b0;
    logic        prev_freeze, prev_req, prev_ready, prev_valid;
    logic [31:0] prev_addr, prev_ifpc, prev_instr;

    // Monitor: every instruction handed to ID must match the next program-order entry.
    always @(negedge clk) begin
        if (sb_en) begin
            logic [63:0] e;
            #1;
            if (ifIdValid && !freeze) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_instr", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ifIdPC", ifIdPC, e[63:32]);
                    check("sb_ifIdInstr", ifIdInstr, e[31:0]);
                end
            end
            if (have_prev && prev_freeze) begin
                check("freeze_hold_pc", ifIdPC, prev_ifpc);
                check("freeze_hold_instr", ifIdInstr, prev_instr);
                check("freeze_hold_valid", 32'(ifIdValid), 32'(prev_valid));
            end
            if (have_prev && prev_req && !prev_ready)
                check("addr_stable", bus.addr, prev_addr);
            have_prev   = 1'b1;
            prev_freeze = freeze;
            prev_req    = bus.req;
            prev_ready  = bus.ready;
            prev_valid  = ifIdValid;
            prev_addr   = bus.addr;
            prev_ifpc   = ifIdPC;
            prev_instr  = ifIdInstr;
        end
    end

    initial begin
        bus.ready = 1'b0;
        // Reset
        tick(); tick();
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(ifIdValid), 32'd0);
        check("rst_ifIdPC", ifIdPC, 32'h0);
        check("rst_ifIdInstr", ifIdInstr, 32'h0);
        check("rst_req", 32'(bus.req), 32'd1);
        check("rst_addr", bus.addr, 32'h0);
        check("wrap_first_addr", bus2.addr, 32'hFFFF_FFFC);

        // Zero-wait streaming
        bus.ready = 1'b1;
        tick();
        check("zw_addr1", bus.addr, 32'h4);
        check("zw_ifpc1", ifIdPC, 32'h4);
        check("zw_instr1", ifIdInstr, 32'h0 ^ K);
        check("zw_valid1", 32'(ifIdValid), 32'd1);
        check("wrap_second_addr", bus2.addr, 32'h0);
        check("wrap_ifIdPC", ifIdPC2, 32'h0);
        tick();
        check("zw_addr2", bus.addr, 32'h8);
        check("zw_ifpc2", ifIdPC, 32'h8);
        tick();
        check("zw_addr3", bus.addr, 32'hC);
        check("zw_ifpc3", ifIdPC, 32'hC);

        // 3-cycle latency: valid pattern 0,0,1
        bus.ready = 1'b0;
        tick();
        check("lat_addr_a", bus.addr, 32'hC);
        check("lat_valid_a", 32'(ifIdValid), 32'd0);
        tick();
        check("lat_addr_b", bus.addr, 32'hC);
        check("lat_valid_b", 32'(ifIdValid), 32'd0);
        bus.ready = 1'b1;
        tick();
        check("lat_addr_c", bus.addr, 32'h10);
        check("lat_valid_c", 32'(ifIdValid), 32'd1);
        check("lat_ifpc_c", ifIdPC, 32'h10);

        // Freeze while the fetch of 0x10 completes -> HOLD
        freeze = 1'b1;
        tick();
        bus.ready = 1'b0;
        check("hold_req", 32'(bus.req), 32'd0);
        check("hold_pc", pc, 32'h14);
        check("hold_ifpc", ifIdPC, 32'h10);
        tick(); tick(); tick();
        check("hold_ifpc_late", ifIdPC, 32'h10);
        check("hold_instr_late", ifIdInstr, 32'hC ^ K);
        check("hold_req_late", 32'(bus.req), 32'd0);
        freeze = 1'b0;
        tick();
        check("unhold_ifpc", ifIdPC, 32'h14);
        check("unhold_instr", ifIdInstr, 32'h10 ^ K);
        check("unhold_valid", 32'(ifIdValid), 32'd1);
        check("unhold_req", 32'(bus.req), 32'd1);
        check("unhold_addr", bus.addr, 32'h14);

        // Taken branch, zero-wait memory
        bus.ready = 1'b1; brTaken = 1'b1; brTarget = 32'h100;
        tick();
        brTaken = 1'b0;
        check("br_valid", 32'(ifIdValid), 32'd0);
        check("br_addr", bus.addr, 32'h100);
        tick();
        check("br_ifpc", ifIdPC, 32'h104);
        check("br_instr", ifIdInstr, 32'h100 ^ K);

        // Taken branch while a fetch is outstanding -> DISCARD
        bus.ready = 1'b0; brTaken = 1'b1; brTarget = 32'h200;
        tick();
        brTaken = 1'b0;
        check("dis_valid_a", 32'(ifIdValid), 32'd0);
        check("dis_addr_a", bus.addr, 32'h104);
        tick();
        check("dis_addr_b", bus.addr, 32'h104);
        bus.ready = 1'b1;
        tick();
        check("dis_addr_c", bus.addr, 32'h200);
        check("dis_valid_c", 32'(ifIdValid), 32'd0);
        tick();
        check("dis_ifpc", ifIdPC, 32'h204);
        check("dis_valid_d", 32'(ifIdValid), 32'd1);

        // Reset while in DISCARD
        bus.ready = 1'b0; brTaken = 1'b1; brTarget = 32'h300;
        tick();
        brTaken = 1'b0; rst = 1'b1;
        tick();
        check("rstdis_pc", pc, 32'h0);
        check("rstdis_valid", 32'(ifIdValid), 32'd0);
        check("rstdis_addr", bus.addr, 32'h0);
        rst = 1'b0;

        // Randomized traffic against the program-order model
        model_pc = 32'h0;
        sb_en = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            bus.ready = ($urandom_range(0, 9) < 6);
            freeze    = ($urandom_range(0, 3) == 0);
            brTaken   = ($urandom_range(0, 4) == 0);
            brTarget  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if (ifIdValid && !freeze) begin
                exp_q.push_back({model_pc + 32'd4, model_pc ^ K});
                model_pc = brTaken ? brTarget : model_pc + 32'd4;
                consumed++;
            end
        end
        #2;
        sb_en = 1'b0;
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        tests++;
        if (consumed < 300) begin
            fails++;
            $display("FAIL sb_throughput: got %0d instructions expected at least 300", consumed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage branch condition logic.
- Owns the PC register and drives a variable-latency instruction-memory request/response interface.
- Holds the IF/ID pipeline register.
- Consumes the ID stage's taken-branch decision and target: on a taken branch it redirects the PC and squashes any wrong-path fetch. No delay slot.

Parameters:
- WORD_LEN, 32, datapath/address width.
- RESET_PC, 0, PC value after reset.
- PC_STEP, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard-unit stall; 1 = ID is not accepting, so IF/ID must hold.
- brTaken  in  1  taken-branch decision for the instruction currently in IF/ID.
- brTarget  in  WORD_LEN  branch target address, valid when brTaken=1.
- imemReq  out  1  fetch request, level-sensitive.
- imemAddr  out  WORD_LEN  fetch address; stable while imemReq=1 until imemReady.
- imemReady  in  1  response strobe; completes the outstanding request this cycle (zero-wait allowed).
- imemData  in  WORD_LEN  instruction word, valid when imemReady=1.
- pc  out  WORD_LEN  current PC register.
- ifIdPC  out  WORD_LEN  IF/ID: fetched PC + PC_STEP.
- ifIdInstr  out  WORD_LEN  IF/ID: instruction word.
- ifIdValid  out  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Qualified branch: take = brTaken & ifIdValid & ~freeze. brTaken is ignored otherwise.
- Reset (rst=1 at an edge):
  - pc=RESET_PC; state=FETCH.
  - ifIdValid=0, ifIdInstr=0, ifIdPC=0.
  - Buffer and saved target cleared.
  - rst overrides all other inputs.
  - An outstanding request is abandoned; memory must tolerate this.
- States: FETCH, HOLD, DISCARD.
- Outputs per state:
  - imemReq = 1 in FETCH and DISCARD, 0 in HOLD.
  - imemAddr = pc always.
  - pc does not change while a request is outstanding.
- FETCH, priority top-down:
  - take & imemReady: drop imemData; pc<=brTarget; ifIdValid<=0; stay FETCH.
  - take & ~imemReady: savedTarget<=brTarget; ifIdValid<=0; ->DISCARD.
  - imemReady & ~freeze: IF/ID<={pc+PC_STEP, imemData, 1}; pc<=pc+PC_STEP; stay FETCH.
  - imemReady & freeze: buffer<={pc+PC_STEP, imemData}; pc<=pc+PC_STEP; IF/ID holds; ->HOLD.
  - ~imemReady & ~freeze: ifIdValid<=0 (bubble).
  - ~imemReady & freeze: IF/ID holds.
- HOLD:
  - freeze: all state holds.
  - ~freeze & take: discard buffer; pc<=brTarget; ifIdValid<=0; ->FETCH.
  - ~freeze & ~take: IF/ID<=buffer with valid=1; ->FETCH.
  - The next request starts the following cycle.
- DISCARD:
  - Keep requesting the old pc until imemReady.
  - On imemReady: drop data; pc<=savedTarget; ->FETCH.
  - IF/ID stays invalid throughout, so brTaken is unqualified here.
- Latency and throughput:
  - Zero-wait memory, no stalls: one instruction per cycle.
  - Data returned at edge N appears on IF/ID after edge N.
- Arithmetic: pc+PC_STEP wraps modulo 2^WORD_LEN with no flag.
- While freeze=1, ifIdPC, ifIdInstr and ifIdValid are bit-stable.

Test Plan:
- Reset, zero-wait memory (imemReady=1, imemData=addr^0xA5A5A5A5), freeze=0 → imemAddr 0,4,8,12 on consecutive cycles; ifIdPC 4,8,12; ifIdValid=1 from cycle 2.
- Memory latency 3 cycles (imemReady every 3rd cycle), no freeze → imemAddr stable 3 cycles each; ifIdValid pattern 0,0,1 repeating.
- IF/ID holds pc 0x10; freeze=1 for 4 cycles while fetch of 0x14 completes → IF/ID stays 0x14/instr@0x10; state HOLD; imemReq=0. Freeze drops → IF/ID=0x18/instr@0x14, then fetch resumes at 0x18.
- ifIdValid=1, brTaken=1, brTarget=0x100, zero-wait memory → next cycle ifIdValid=0 and imemAddr=0x100; then ifIdPC=0x104.
- brTaken with target 0x200 while a 3-cycle fetch of 0x20 is outstanding → DISCARD; imemAddr stays 0x20 until ready; data dropped; next imemAddr=0x200; no invalid instruction reaches IF/ID.
- brTaken=1 with freeze=1 → ignored, no redirect. RESET_PC=0xFFFFFFFC → second fetch address 0x0 (wrap). rst asserted in DISCARD → pc=RESET_PC and ifIdValid=0 next cycle.
